// File: rtl/seq_gen_1001.sv
// Serial pattern transmitter: sends PATTERN MSB first, reps times,
// with GAP idle cycles between patterns and a start/busy/done handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       transaction request, sampled only while busy==0
//   reps        repetition count, latched on accepted start (0 acts as 1)
//   out         serial data, 0 whenever out_valid==0
//   out_valid   high while a pattern bit is on out
//   frame_start pulse with the first bit of each pattern
//   busy        high from accepted start until done
//   done        one-cycle pulse after the last bit of the last pattern
module seq_gen_1001 #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
    parameter int               CNT_W   = 8,
    parameter int               GAP     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [IW-1:0] IDX_TOP = IW'(PAT_W - 1);
    localparam logic [GW-1:0] GAP_LD  = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAPW,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             fs_q, fs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IW-1:0]    idx_dec;

    // idx_q is the index of the bit currently on the line, so the
    // next-state logic presents the bit that will be visible next cycle.
    assign idx_dec = idx_q - 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        fs_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SEND;
                    idx_d   = IDX_TOP;
                    rep_d   = (reps == '0) ? ONE : reps;
                    out_d   = PATTERN[IDX_TOP];
                    valid_d = 1'b1;
                    fs_d    = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SEND: begin
                if (idx_q != '0) begin
                    idx_d   = idx_dec;
                    out_d   = PATTERN[idx_dec];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_q > ONE) begin
                    rep_d  = rep_q - ONE;
                    busy_d = 1'b1;
                    if (GAP > 0) begin
                        state_d = S_GAPW;
                        gap_d   = GAP_LD;
                    end else begin
                        idx_d   = IDX_TOP;
                        out_d   = PATTERN[IDX_TOP];
                        valid_d = 1'b1;
                        fs_d    = 1'b1;
                    end
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end

            S_GAPW: begin
                busy_d = 1'b1;
                if (gap_q == '0) begin
                    state_d = S_SEND;
                    idx_d   = IDX_TOP;
                    out_d   = PATTERN[IDX_TOP];
                    valid_d = 1'b1;
                    fs_d    = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = valid_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_gen_1001.sv
// Bench for seq_gen_1001: GAP=2 and GAP=0 instances against a
// per-cycle expected-output scoreboard built from the timing rules.
module tb_seq_gen_1001;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] reps;

    logic o0, v0, f0, b0, d0;
    logic o1, v1, f1, b1, d1;

    always #5 clk = ~clk;

    seq_gen_1001 #(.GAP(2)) dut0 (
        .clk(clk), .rst(rst), .start(start), .reps(reps),
        .out(o0), .out_valid(v0), .frame_start(f0),
        .busy(b0), .done(d0)
    );

    seq_gen_1001 #(.GAP(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .reps(reps),
        .out(o1), .out_valid(v1), .frame_start(f1),
        .busy(b1), .done(d1)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    localparam logic [3:0] PAT = 4'b1001;

    // tuple = {out, out_valid, frame_start, busy, done}
    logic [4:0] tq[$];
    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [4:0] cur0 = '0;
    logic [4:0] cur1 = '0;

    logic [3:0] sh  = '0;
    int         det = 0;

    // Whole transaction as seen after the accepting edge.
    function automatic void build(input int g, input int r_in);
        int rr;
        rr = (r_in == 0) ? 1 : r_in;
        tq.delete();
        for (int r = 0; r < rr; r++) begin
            for (int k = 0; k < 4; k++)
                tq.push_back({PAT[3-k], 1'b1, k == 0, 1'b1, 1'b0});
            if (r < rr - 1)
                for (int j = 0; j < g; j++)
                    tq.push_back(5'b00010);
        end
        tq.push_back(5'b00001);
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) begin
            q0.delete();
            cur0 = '0;
        end else if (start && !cur0[1]) begin
            build(2, int'(reps));
            q0 = tq;
            cur0 = q0.pop_front();
        end else begin
            cur0 = (q0.size() > 0) ? q0.pop_front() : 5'b0;
        end
        if (rst) begin
            q1.delete();
            cur1 = '0;
        end else if (start && !cur1[1]) begin
            build(0, int'(reps));
            q1 = tq;
            cur1 = q1.pop_front();
        end else begin
            cur1 = (q1.size() > 0) ? q1.pop_front() : 5'b0;
        end
        #1;
        if (v1) begin
            sh = {sh[2:0], o1};
            if (sh == 4'b1001) det++;
        end
        chk("gap2", {o0, v0, f0, b0, d0}, cur0);
        chk("gap0", {o1, v1, f1, b1, d1}, cur1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        reps  = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // single pattern
        start = 1'b1; reps = 8'd1;
        step();
        start = 1'b0;
        repeat (6) step();

        // repeats with gap
        start = 1'b1; reps = 8'd3;
        step();
        start = 1'b0;
        repeat (20) step();

        // reps=0 acts as 1
        start = 1'b1; reps = 8'd0;
        step();
        start = 1'b0;
        repeat (7) step();

        // contiguous on GAP=0
        start = 1'b1; reps = 8'd2;
        step();
        start = 1'b0;
        repeat (14) step();

        // start held high, reps wiggling while busy
        start = 1'b1; reps = 8'd2;
        step();
        repeat (40) begin
            reps = 8'($urandom_range(0, 5));
            step();
        end
        start = 1'b0;
        repeat (25) step();

        // reset in third bit of second pattern (gap2 instance)
        start = 1'b1; reps = 8'd2;
        step();
        start = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        start = 1'b1; reps = 8'd3;
        step();
        start = 1'b0;
        repeat (20) step();

        // loopback into a 1001 detector on the GAP=0 stream
        sh  = '0;
        det = 0;
        start = 1'b1; reps = 8'd4;
        step();
        start = 1'b0;
        repeat (30) step();
        chk("det", 32'(det), 32'd4);

        // random traffic
        repeat (400) begin
            start = ($urandom_range(0, 3) == 0);
            reps  = 8'($urandom_range(0, 4));
            rst   = ($urandom_range(0, 80) == 0);
            step();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (30) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
